// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and queue payload for the instruction-fetch front end.
package if_fetch_unit_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned QDEPTH_DEF = 4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;
  localparam logic [3:0] OP_HALT_DEF = 4'hF;
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;

  // Prefetch queue entry: NextPC of the word plus the word itself.
  typedef struct packed {
    logic [ADDR_W-1:0] pc1;
    logic [DATA_W-1:0] instr;
  } fq_entry_t;

  function automatic logic [OP_MSB-OP_LSB:0] opcode(input logic [DATA_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Prefetch FIFO with wrapping pointers, flush and occupancy count.
module if_fetch_unit_fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEF
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         push,
  input  fq_entry_t                    push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output fq_entry_t                    head,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fq_entry_t        mem_q [QDEPTH];
  fq_entry_t        mem_d [QDEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is only consumed when count is non-zero.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  full_push_a: assert property (@(posedge Clk) disable iff (!Rst)
    !(push && !flush && (count_q == CNT_W'(QDEPTH))));

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: credit-based issue to imem, redirect flush/discard, HALT stop.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned       QDEPTH   = QDEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [3:0]        OP_HALT  = OP_HALT_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              halted
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              inflight_q, inflight_d;
  logic              discard_q, discard_d;
  logic              halted_q, halted_d;

  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credits_used;
  logic              halt_hit;
  logic              resp_ok;
  logic              push;
  logic              pop;
  logic              occupied;
  fq_entry_t         push_entry;
  fq_entry_t         head;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    inflight_d = 1'b0;
    discard_d  = 1'b0;
    halted_d   = halted_q;

    resp_ok      = imem_valid && inflight_q && !discard_q;
    halt_hit     = imem_valid && !discard_q && (opcode(imem_rdata) == OP_HALT);
    credits_used = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_q);
    // Credits count queued plus in-flight words so a response always has a slot.
    imem_req     = Rst && !halted_q && !redirect_valid && !halt_hit &&
                   (credits_used < (CNT_W+1)'(QDEPTH));
    imem_addr    = fetch_pc_q;

    push         = resp_ok && !redirect_valid;
    push_entry   = '{pc1: req_addr_q + ADDR_W'(1), instr: imem_rdata};

    occupied     = (count != '0);
    id_valid     = occupied && !redirect_valid;
    pop          = id_valid && id_ready;
    id_instr     = occupied ? head.instr : '0;
    id_pc        = occupied ? head.pc1 : '0;

    if (imem_req) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      req_addr_d = fetch_pc_q;
      inflight_d = 1'b1;
    end
    if (push && (opcode(imem_rdata) == OP_HALT)) begin
      halted_d = 1'b1;
    end

    // Redirect overrides issue, enqueue and halt.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      discard_d  = inflight_q;
      halted_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      halted_q   <= halted_d;
    end
  end

  assign halted = halted_q;

  if_fetch_unit_fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_fetch_queue (
    .Clk        (Clk),
    .Rst        (Rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model plus directed scenarios.
module tb_if_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        halted;

  logic        mem_valid = 1'b0;
  logic [15:0] mem_data  = 16'h0000;
  logic        stray;
  logic [15:0] stray_data;
  logic        halt_en;
  logic [15:0] halt_addr;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: fetch pointer, last-cycle issue, discard, halt, queue.
  logic [15:0] m_pc       = 16'h0000;
  logic        m_issued   = 1'b0;
  logic [15:0] m_iss_addr = 16'h0000;
  logic [15:0] m_iss_data = 16'h0000;
  logic        m_drop     = 1'b0;
  logic        m_halted   = 1'b0;
  logic [31:0] mq[$];

  always #5 Clk = ~Clk;

  if_fetch_unit dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .halted         (halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hF000;
    return 16'h1000 | (a & 16'h0FFF);
  endfunction

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge Clk) begin
    mem_valid <= imem_req;
    mem_data  <= mem_word(imem_addr);
  end
  assign imem_valid = mem_valid | stray;
  assign imem_rdata = mem_valid ? mem_data : stray_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge Clk) begin
    logic        rv;
    logic [15:0] rd;
    logic        hh;
    logic        e_valid;
    logic        e_req;
    if (Rst === 1'b1) begin
      rv      = m_issued || stray;
      rd      = m_issued ? m_iss_data : stray_data;
      hh      = rv && !m_drop && (rd[15:12] == 4'hF);
      e_valid = (mq.size() != 0) && !redirect_valid;
      e_req   = !m_halted && !redirect_valid && !hh &&
                (mq.size() + (m_issued ? 1 : 0) < 4);
      chk("m_imem_req", imem_req, e_req);
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_id_valid", id_valid, e_valid);
      chk("m_halted", halted, m_halted);
      if (e_valid) begin
        chk("m_id_instr", id_instr, mq[0][15:0]);
        chk("m_id_pc", id_pc, mq[0][31:16]);
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc     = redirect_pc;
        m_halted = 1'b0;
        m_drop   = m_issued;
        m_issued = 1'b0;
      end else begin
        if (e_valid && id_ready) void'(mq.pop_front());
        if (m_issued && !m_drop) begin
          mq.push_back({m_iss_addr + 16'h0001, rd});
          if (rd[15:12] == 4'hF) m_halted = 1'b1;
        end
        m_drop = 1'b0;
        if (e_req) begin
          m_iss_addr = m_pc;
          m_iss_data = mem_word(m_pc);
          m_pc       = m_pc + 16'h0001;
          m_issued   = 1'b1;
        end else begin
          m_issued = 1'b0;
        end
      end
    end else begin
      mq.delete();
      m_pc     = 16'h0000;
      m_issued = 1'b0;
      m_drop   = 1'b0;
      m_halted = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic ok;
    Rst = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    stray = 1'b0; stray_data = 16'h0000; halt_en = 1'b0; halt_addr = 16'h0000;
    cyc(); cyc();
    @(negedge Clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 16'h0000);
    chk("rst_pc", id_pc, 16'h0000);
    chk("rst_halted", halted, 0);

    // Startup latency, then stall with decode not ready: queue fills with 0..3.
    cyc(); Rst = 1'b1; id_ready = 1'b0;
    @(negedge Clk); chk("c0_req", imem_req, 1); chk("c0_addr", imem_addr, 16'h0000);
    cyc(); @(negedge Clk); chk("c1_addr", imem_addr, 16'h0001); chk("c1_valid", id_valid, 0);
    cyc(); @(negedge Clk);
    chk("c2_valid", id_valid, 1); chk("c2_instr", id_instr, 16'h1000); chk("c2_pc", id_pc, 16'h0001);
    repeat (7) cyc();
    @(negedge Clk);
    chk("stall_req", imem_req, 0); chk("stall_addr", imem_addr, 16'h0004);
    chk("model_full", mq.size(), 4);
    cyc(); id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("drain_valid", id_valid, 1);
      chk("drain_pc", id_pc, 32'(k + 1));
      chk("drain_instr", id_instr, 32'(16'h1000 + k));
      cyc();
    end
    repeat (6) cyc();

    // Redirect with three queued and one in flight.
    id_ready = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (mq.size() == 3 && m_issued) begin ok = 1'b1; break; end
      cyc();
    end
    chk("reach_q3_inflight", ok, 1);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    @(negedge Clk); chk("rd_valid", id_valid, 0); chk("rd_req", imem_req, 0);
    cyc(); redirect_valid = 1'b0; id_ready = 1'b1;
    @(negedge Clk);
    chk("rd_addr", imem_addr, 16'h0040); chk("rd_req_next", imem_req, 1); chk("rd_flushed", id_valid, 0);
    ok = 1'b0;
    for (int t = 0; t < 8; t++) begin
      cyc(); @(negedge Clk);
      if (id_valid) begin ok = 1'b1; break; end
    end
    chk("rd_first_seen", ok, 1);
    chk("rd_first_instr", id_instr, 16'h1040); chk("rd_first_pc", id_pc, 16'h0041);

    // HALT returned for address 5.
    cyc(); halt_en = 1'b1; halt_addr = 16'h0005; redirect_valid = 1'b1; redirect_pc = 16'h0000;
    cyc(); redirect_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge Clk);
      if (imem_valid && imem_rdata == 16'hF000) begin ok = 1'b1; break; end
      cyc();
    end
    chk("halt_seen", ok, 1);
    chk("halt_noreq", imem_req, 0);
    cyc(); @(negedge Clk); chk("halted_set", halted, 1);
    ok = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (id_valid && id_instr == 16'hF000) begin ok = 1'b1; break; end
      cyc(); @(negedge Clk);
    end
    chk("halt_delivered", ok, 1); chk("halt_pc", id_pc, 16'h0006);
    repeat (4) cyc();
    @(negedge Clk); chk("halt_hold_req", imem_req, 0); chk("halt_hold", halted, 1);
    cyc(); halt_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0010;
    @(negedge Clk); chk("halt_rd_cycle", halted, 1);
    cyc(); redirect_valid = 1'b0;
    @(negedge Clk);
    chk("resume_halted", halted, 0); chk("resume_addr", imem_addr, 16'h0010); chk("resume_req", imem_req, 1);

    // Address wrap at 0xFFFF.
    cyc(); redirect_valid = 1'b1; redirect_pc = 16'hFFFD;
    cyc(); redirect_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge Clk);
      if (imem_req && imem_addr == 16'hFFFF) begin ok = 1'b1; break; end
      cyc();
    end
    chk("wrap_ffff_req", ok, 1);
    cyc(); @(negedge Clk); chk("wrap_addr", imem_addr, 16'h0000);
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (id_valid && id_instr == 16'h1FFF) begin ok = 1'b1; break; end
      cyc(); @(negedge Clk);
    end
    chk("wrap_seen", ok, 1); chk("wrap_pc", id_pc, 16'h0000);

    // Reset with two queued and one in flight, then a stray response.
    cyc(); id_ready = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (mq.size() == 2 && m_issued) begin ok = 1'b1; break; end
      cyc();
    end
    chk("reach_q2_inflight", ok, 1);
    Rst = 1'b0;
    cyc(); Rst = 1'b1; stray = 1'b1; stray_data = 16'h2222;
    @(negedge Clk);
    chk("mrst_valid", id_valid, 0); chk("mrst_addr", imem_addr, 16'h0000); chk("mrst_req", imem_req, 1);
    cyc(); stray = 1'b0; id_ready = 1'b1;
    @(negedge Clk); chk("stray_ignored", id_valid, 0); chk("mrst_addr1", imem_addr, 16'h0001);
    cyc(); @(negedge Clk);
    chk("mrst_first_valid", id_valid, 1); chk("mrst_first_instr", id_instr, 16'h1000);
    chk("mrst_first_pc", id_pc, 16'h0001);
    repeat (5) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
